// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp refresh controller.
package lamp_pkg;

    localparam int c_frame_bits = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_LATCH = 2'd3
    } lamp_state_e;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// Free-running divider: one-cycle o_tick every c_freq/c_rate_hz clocks.
module lamp_tick_gen #(
    parameter int c_freq    = 20000000,
    parameter int c_rate_hz = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int c_period = c_freq / c_rate_hz;
    localparam int c_cnt_w  = (c_period > 1) ? $clog2(c_period) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_period - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Count 0..period-1 and wrap; the wrap cycle is the tick.
    always_comb begin
        o_tick = (cnt_q == c_last);
        cnt_d  = o_tick ? '0 : cnt_q + c_cnt_w'(1);
    end

    // Counter register.
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lamp_refresh_ctrl.sv
// Double-buffered LED frame controller: shift, idle gap, latch, periodic refresh.
module lamp_refresh_ctrl
    import lamp_pkg::*;
#(
    parameter int c_freq       = 20000000,
    parameter int c_refresh_hz = 100,
    parameter int c_gap_cycles = 20,
    parameter int c_lat_cycles = 4,
    parameter int c_sh_timeout = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frm_valid,
    input  logic [c_frame_bits-1:0] i_frm_data,
    output logic                    o_frm_ready,
    output logic                    o_sh_start,
    output logic [c_frame_bits-1:0] o_sh_data,
    input  logic                    i_sh_done,
    output logic                    o_lat,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int c_tmr_w = $clog2(max3(c_gap_cycles, c_lat_cycles, c_sh_timeout) + 1);
    localparam logic [c_tmr_w-1:0] c_to_last  = c_tmr_w'(c_sh_timeout - 1);
    localparam logic [c_tmr_w-1:0] c_gap_last = c_tmr_w'(c_gap_cycles - 1);
    localparam logic [c_tmr_w-1:0] c_lat_last = c_tmr_w'(c_lat_cycles - 1);

    lamp_state_e             state_q, state_d;
    logic [c_tmr_w-1:0]      tmr_q, tmr_d;
    logic [c_frame_bits-1:0] pend_q, pend_d;
    logic [c_frame_bits-1:0] active_q, active_d;
    logic                    pend_full_q, pend_full_d;
    logic                    have_frame_q, have_frame_d;
    logic                    req_q, req_d;
    logic                    err_q, err_d;
    logic                    tick;

    lamp_tick_gen #(
        .c_freq    (c_freq),
        .c_rate_hz (c_refresh_hz)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // Next-state logic: frame intake, refresh request, transfer sequencing.
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        tmr_d        = '0;
        pend_d       = pend_q;
        active_d     = active_q;
        pend_full_d  = pend_full_q;
        have_frame_d = have_frame_q;
        req_d        = req_q;
        err_d        = err_q;

        // A refresh wrap requests a repeat; with nothing shown yet there is nothing to repeat.
        if (tick)          req_d = 1'b1;
        if (!have_frame_q) req_d = 1'b0;

        if (i_frm_valid && !pend_full_q) begin
            pend_d      = i_frm_data;
            pend_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // A new frame takes priority and also consumes any pending refresh.
                if (pend_full_q) begin
                    active_d     = pend_q;
                    pend_full_d  = 1'b0;
                    have_frame_d = 1'b1;
                    req_d        = 1'b0;
                    state_d      = ST_SHIFT;
                end else if (req_q && have_frame_q) begin
                    req_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_sh_done) begin
                    state_d = ST_GAP;
                end else if (tmr_q == c_to_last) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + c_tmr_w'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == c_gap_last) state_d = ST_LATCH;
                else                     tmr_d   = tmr_q + c_tmr_w'(1);
            end
            ST_LATCH: begin
                if (tmr_q == c_lat_last) state_d = ST_IDLE;
                else                     tmr_d   = tmr_q + c_tmr_w'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; both frame buffers clear so reset discards them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            pend_q       <= '0;
            active_q     <= '0;
            pend_full_q  <= 1'b0;
            have_frame_q <= 1'b0;
            req_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            pend_q       <= pend_d;
            active_q     <= active_d;
            pend_full_q  <= pend_full_d;
            have_frame_q <= have_frame_d;
            req_q        <= req_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode straight from registers, so reset drops them at once.
    always_comb begin
        o_frm_ready = !pend_full_q;
        o_sh_start  = (state_q == ST_SHIFT) && (tmr_q == '0);
        o_sh_data   = active_q;
        o_lat       = (state_q == ST_LATCH);
        o_busy      = (state_q != ST_IDLE);
        o_err       = err_q;
    end

endmodule

// File: tb/tb_lamp_refresh_ctrl.sv
// Self-checking bench for lamp_refresh_ctrl: directed scenarios plus a randomized scoreboard run.
module tb_lamp_refresh_ctrl;

    localparam int c_freq     = 1000;
    localparam int c_rate     = 10;
    localparam int c_period   = c_freq / c_rate;
    localparam int c_gap      = 20;
    localparam int c_lat      = 4;
    localparam int c_to       = 200;
    localparam int c_done_dly = 50;
    localparam logic [127:0] c_frame0 = 128'h000e0078001001001001800800800800;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_frm_valid = 1'b0;
    logic [127:0] i_frm_data = '0;
    logic         i_sh_done = 1'b0;
    logic         o_frm_ready, o_sh_start, o_lat, o_busy, o_err;
    logic [127:0] o_sh_data;

    lamp_refresh_ctrl #(
        .c_freq       (c_freq),
        .c_refresh_hz (c_rate),
        .c_gap_cycles (c_gap),
        .c_lat_cycles (c_lat),
        .c_sh_timeout (c_to)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frm_valid (i_frm_valid),
        .i_frm_data  (i_frm_data),
        .o_frm_ready (o_frm_ready),
        .o_sh_start  (o_sh_start),
        .o_sh_data   (o_sh_data),
        .i_sh_done   (i_sh_done),
        .o_lat       (o_lat),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Observed transfers and latch history.
    int           start_cyc[$];
    logic [127:0] start_dat[$];
    int           done_cnt = 0;
    int           last_done = -1000;
    int           lat_rise = 0;
    int           nlat = 0;
    bit           lat_prev = 1'b0;
    bit           lat_chk_en = 1'b1;
    bit           shift_en = 1'b1;

    // Scoreboard: accepted frames in order, with acceptance cycle.
    bit           sb_en = 1'b0;
    logic [127:0] exp_dat[$];
    int           exp_acc[$];
    logic [127:0] last_frame = '0;
    bit           have_last = 1'b0;

    // A start shows the oldest accepted frame once it has had time to reach the
    // active buffer (accepted edge, then one edge in IDLE); otherwise it must be
    // a refresh of the last frame shown.
    task automatic score_start();
        if (exp_dat.size() > 0 && exp_acc[0] <= cyc - 2) begin
            check("new_frame_order", o_sh_data, exp_dat[0]);
            last_frame = exp_dat.pop_front();
            void'(exp_acc.pop_front());
            have_last = 1'b1;
        end else if (have_last) begin
            check("refresh_repeats_last", o_sh_data, last_frame);
        end else begin
            check("start_without_frame", o_sh_start, 1'b0);
        end
    endtask

    // Shift-engine model and output monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst) begin
            done_cnt  = 0;
            i_sh_done = 1'b0;
            lat_prev  = 1'b0;
        end else begin
            i_sh_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    i_sh_done = 1'b1;
                    last_done = cyc;
                end
            end
            if (o_sh_start) begin
                start_cyc.push_back(cyc);
                start_dat.push_back(o_sh_data);
                if (shift_en) done_cnt = c_done_dly;
                if (sb_en) score_start();
            end
            if (o_lat && !lat_prev) begin
                lat_rise = cyc;
                if (start_dat.size() > 0) check("sh_data_at_latch", o_sh_data, start_dat[$]);
            end
            if (!o_lat && lat_prev) begin
                nlat++;
                if (lat_chk_en) begin
                    check("latch_delay_after_done", lat_rise - last_done, c_gap + 1);
                    check("latch_width", cyc - lat_rise, c_lat);
                end
            end
            lat_prev = o_lat;
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_frm_valid = 1'b0;
        i_frm_data  = '0;
        repeat (3) @(negedge i_clk);
        start_cyc.delete();
        start_dat.delete();
        exp_dat.delete();
        exp_acc.delete();
        have_last = 1'b0;
        nlat      = 0;
        i_rst     = 1'b0;
    endtask

    // Offer a frame (call right after a falling edge); returns acceptance cycle and wait length.
    task automatic send(input logic [127:0] d, input int budget, output int acc, output int waited);
        waited      = 0;
        i_frm_valid = 1'b1;
        i_frm_data  = d;
        while (!o_frm_ready && waited < budget) begin
            @(negedge i_clk);
            waited++;
        end
        acc = cyc;
        check("frm_ready_at_accept", o_frm_ready, 1'b1);
        if (sb_en) begin
            exp_dat.push_back(d);
            exp_acc.push_back(acc);
        end
        @(negedge i_clk);
        i_frm_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k;
        k = 0;
        while (start_cyc.size() < n && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check("start_count_reached", start_cyc.size(), n);
    endtask

    task automatic wait_latches(input int n, input int budget);
        int k;
        k = 0;
        while (nlat < n && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check("latch_count_reached", nlat, n);
    endtask

    function automatic logic [127:0] rand_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, w, acc3, w3, s;
        logic [127:0] f1, f2, f3, fr;

        // Reset values.
        do_reset();
        check("rst_frm_ready", o_frm_ready, 1'b1);
        check("rst_sh_start", o_sh_start, 1'b0);
        check("rst_sh_data", o_sh_data, '0);
        check("rst_lat", o_lat, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err, 1'b0);

        // No frame: refresh ticks never start a transfer.
        repeat (500) @(negedge i_clk);
        check("idle_no_start", start_cyc.size(), 0);
        check("idle_no_latch", nlat, 0);

        // Single frame: one start, correct data, latch timing (monitor).
        do_reset();
        send(c_frame0, 10, acc, w);
        wait_starts(1, 20);
        check("frame0_data", start_dat[0], c_frame0);
        check("frame0_busy", o_busy, 1'b1);
        wait_latches(1, 200);
        check("frame0_single_start", start_cyc.size(), 1);
        check("frame0_idle_after", o_busy, 1'b0);

        // One frame then idle: identical repeats every refresh period.
        do_reset();
        f1 = rand_frame();
        send(f1, 10, acc, w);
        wait_starts(1, 20);
        repeat (350) @(negedge i_clk);
        check("refresh_count_at_least_4", start_cyc.size() >= 4, 1'b1);
        for (int i = 1; i < start_cyc.size(); i++) begin
            check("refresh_data_same", start_dat[i], f1);
            if (i >= 2) check("refresh_interval", start_cyc[i] - start_cyc[i-1], c_period);
        end

        // Three frames back-to-back: second buffered, third back-pressured.
        do_reset();
        f1 = rand_frame();
        f2 = rand_frame();
        f3 = rand_frame();
        send(f1, 10, acc, w);
        check("f1_no_wait", w, 0);
        send(f2, 10, acc, w);
        check("f2_accepted_during_first_xfer", nlat, 0);
        send(f3, 300, acc3, w3);
        check("f3_stalled", w3 > 0, 1'b1);
        check("f3_after_first_xfer_done", nlat >= 1, 1'b1);
        wait_starts(3, 300);
        check("order_f1", start_dat[0], f1);
        check("order_f2", start_dat[1], f2);
        check("order_f3", start_dat[2], f3);

        // Randomized frame arrivals against the scoreboard.
        do_reset();
        sb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 180)) @(negedge i_clk);
            fr = rand_frame();
            send(fr, 300, acc, w);
        end
        repeat (400) @(negedge i_clk);
        check("all_frames_shown", exp_dat.size(), 0);
        sb_en = 1'b0;

        // Reset asserted during LATCH.
        do_reset();
        send(rand_frame(), 10, acc, w);
        begin
            int k;
            k = 0;
            while (!o_lat && k < 200) begin
                @(negedge i_clk);
                k++;
            end
        end
        check("reached_latch", o_lat, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        check("rst_in_latch_lat", o_lat, 1'b0);
        check("rst_in_latch_start", o_sh_start, 1'b0);
        check("rst_in_latch_ready", o_frm_ready, 1'b1);
        check("rst_in_latch_data", o_sh_data, '0);
        repeat (2) @(negedge i_clk);
        start_cyc.delete();
        start_dat.delete();
        nlat  = 0;
        i_rst = 1'b0;
        repeat (300) @(negedge i_clk);
        check("after_rst_no_start", start_cyc.size(), 0);
        check("after_rst_no_latch", nlat, 0);

        // Shift engine never answers: timeout, sticky error, no latch.
        do_reset();
        shift_en = 1'b0;
        send(rand_frame(), 10, acc, w);
        wait_starts(1, 20);
        s = (start_cyc.size() > 0) ? start_cyc[0] : cyc;
        while (cyc < s + c_to - 1) @(negedge i_clk);
        check("timeout_err_before", o_err, 1'b0);
        check("timeout_busy_before", o_busy, 1'b1);
        @(negedge i_clk);
        check("timeout_err_set", o_err, 1'b1);
        check("timeout_idle", o_busy, 1'b0);
        check("timeout_no_latch", nlat, 0);
        repeat (150) @(negedge i_clk);
        check("timeout_err_sticky", o_err, 1'b1);
        shift_en = 1'b1;
        do_reset();
        check("err_cleared_by_reset", o_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
